// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port unified memory between the vector
// fetch (VEC), the memory-stage data access (DAT) and instruction fetch (FET).
// Serializes accesses, waits out the memory read latency and returns read data
// to the requester that issued the read.
// Optional build macro: MEM_ARB_PERF_EN adds the conflict_cnt output.
//
// state | meaning
// IDLE  | accepting requests; a grant drives the memory in this same cycle
// WAIT  | read in flight; address held, no grants until data is captured
module mem_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int LAT       = 1,
  parameter int DAT_BURST = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vec_req,
  input  logic [ADDR_W-1:0] vec_addr,
  input  logic              dat_req,
  input  logic              dat_we,
  input  logic [ADDR_W-1:0] dat_addr,
  input  logic [DATA_W-1:0] dat_wdata,
  input  logic              fet_req,
  input  logic [ADDR_W-1:0] fet_addr,
  output logic              vec_gnt,
  output logic              dat_gnt,
  output logic              fet_gnt,
  output logic              vec_rvalid,
  output logic              dat_rvalid,
  output logic              fet_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,output logic [15:0]      conflict_cnt
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [1:0] LAT_LAST  = 2'(LAT - 1);
  localparam logic [1:0] BURST_MAX = 2'(DAT_BURST);
  localparam logic [1:0] OWN_VEC   = 2'd0;
  localparam logic [1:0] OWN_DAT   = 2'd1;
  localparam logic [1:0] OWN_FET   = 2'd2;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [1:0]          burst_q;
  logic [1:0]          owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                read_issue;
  logic                capture;

  // Arbitration, memory drive and next-state selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    vec_gnt    = 1'b0;
    dat_gnt    = 1'b0;
    fet_gnt    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_q;
    mem_wdata  = '0;
    read_issue = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held so outputs sit at reset values.
        if (!reset) begin
          if (vec_req) begin
            vec_gnt    = 1'b1;
            mem_addr   = vec_addr;
            read_issue = 1'b1;
            owner_d    = OWN_VEC;
          end else if (fet_req && (!dat_req || burst_q == BURST_MAX)) begin
            fet_gnt    = 1'b1;
            mem_addr   = fet_addr;
            read_issue = 1'b1;
            owner_d    = OWN_FET;
          end else if (dat_req) begin
            dat_gnt  = 1'b1;
            mem_addr = dat_addr;
            if (dat_we) begin
              mem_we    = 1'b1;
              mem_wdata = dat_wdata;
            end else begin
              read_issue = 1'b1;
              owner_d    = OWN_DAT;
            end
          end
        end
        if (read_issue) begin
          mem_re  = 1'b1;
          state_d = WAIT;
          cnt_d   = 2'd0;
        end
      end
      WAIT: begin
        if (cnt_q == LAT_LAST) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched read context, returned data and DAT burst tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      burst_q    <= 2'd0;
      owner_q    <= OWN_VEC;
      addr_q     <= '0;
      rdata      <= '0;
      vec_rvalid <= 1'b0;
      dat_rvalid <= 1'b0;
      fet_rvalid <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      if (read_issue) addr_q <= mem_addr;
      if (capture) rdata <= mem_rdata;
      vec_rvalid <= capture && (owner_q == OWN_VEC);
      dat_rvalid <= capture && (owner_q == OWN_DAT);
      fet_rvalid <= capture && (owner_q == OWN_FET);
      if (fet_gnt || !fet_req) burst_q <= 2'd0;
      else if (dat_gnt && burst_q != BURST_MAX) burst_q <= burst_q + 2'd1;
    end
  end

  assign busy = (state_q == WAIT);

`ifdef MEM_ARB_PERF_EN
  logic pending_lost;
  assign pending_lost = (vec_req && !vec_gnt) || (dat_req && !dat_gnt) || (fet_req && !fet_gnt);

  // Saturating count of cycles in which some request waited.
  always_ff @(posedge clk) begin
    if (reset) conflict_cnt <= 16'h0000;
    else if (pending_lost && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a cycle table at LAT=1 with a read-data
// scoreboard, plus hand sequences for reset behaviour and a LAT=3 instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] rom(input logic [11:0] a);
    return a[7:0] ^ 8'hB5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- LAT=1 instance ----------------
  logic        reset = 1'b1;
  logic        vec_req = 0, dat_req = 0, dat_we = 0, fet_req = 0;
  logic [11:0] vec_addr = 12'h001, dat_addr = 12'h3FF, fet_addr = 12'h010;
  logic [7:0]  dat_wdata = 8'h5C;
  logic        vec_gnt, dat_gnt, fet_gnt, vec_rvalid, dat_rvalid, fet_rvalid;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;
  logic        mem_re, mem_we, busy;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(8), .LAT(1), .DAT_BURST(3)) u_dut (
    .clk(clk), .reset(reset),
    .vec_req(vec_req), .vec_addr(vec_addr),
    .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr), .dat_wdata(dat_wdata),
    .fet_req(fet_req), .fet_addr(fet_addr),
    .vec_gnt(vec_gnt), .dat_gnt(dat_gnt), .fet_gnt(fet_gnt),
    .vec_rvalid(vec_rvalid), .dat_rvalid(dat_rvalid), .fet_rvalid(fet_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // Memory model: data only valid exactly LAT cycles after mem_re.
  logic        p1_v = 1'b0;
  logic [11:0] p1_a = '0;
  always @(posedge clk) begin
    p1_v <= mem_re;
    p1_a <= mem_addr;
  end
  assign mem_rdata = p1_v ? rom(p1_a) : 8'hEE;

  // ---------------- LAT=3 instance ----------------
  logic        l3_reset = 1'b1;
  logic        l3_dat_req = 0;
  logic [11:0] l3_dat_addr = 12'h123;
  logic        l3_vg, l3_dg, l3_fg, l3_vr, l3_dr, l3_fr;
  logic [7:0]  l3_rdata, l3_mem_wdata, l3_mem_rdata;
  logic [11:0] l3_mem_addr;
  logic        l3_mem_re, l3_mem_we, l3_busy;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] l3_conflict_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(8), .LAT(3), .DAT_BURST(3)) u_dut3 (
    .clk(clk), .reset(l3_reset),
    .vec_req(1'b0), .vec_addr(12'h000),
    .dat_req(l3_dat_req), .dat_we(1'b0), .dat_addr(l3_dat_addr), .dat_wdata(8'h00),
    .fet_req(1'b0), .fet_addr(12'h000),
    .vec_gnt(l3_vg), .dat_gnt(l3_dg), .fet_gnt(l3_fg),
    .vec_rvalid(l3_vr), .dat_rvalid(l3_dr), .fet_rvalid(l3_fr),
    .rdata(l3_rdata), .mem_addr(l3_mem_addr), .mem_re(l3_mem_re), .mem_we(l3_mem_we),
    .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata), .busy(l3_busy)
`ifdef MEM_ARB_PERF_EN
    , .conflict_cnt(l3_conflict_cnt)
`endif
  );

  logic        l3_v [3] = '{default: 1'b0};
  logic [11:0] l3_a [3] = '{default: 12'h000};
  always @(posedge clk) begin
    l3_v[0] <= l3_mem_re;
    l3_a[0] <= l3_mem_addr;
    l3_v[1] <= l3_v[0];
    l3_a[1] <= l3_a[0];
    l3_v[2] <= l3_v[1];
    l3_a[2] <= l3_a[1];
  end
  assign l3_mem_rdata = l3_v[2] ? rom(l3_a[2]) : 8'hEE;

  // ---------------- cycle table ----------------
  typedef struct {
    logic v, d, we, f;
    logic [2:0] gnt;     // {vec, dat, fet}
    logic [2:0] rv;      // {vec, dat, fet}
    logic re, wr, bsy;
    logic [11:0] addr;
  } row_t;

  function automatic row_t mk(input logic v, d, we, f, input logic [2:0] gnt, rv,
                              input logic re, wr, bsy, input logic [11:0] addr);
    row_t r;
    r.v = v; r.d = d; r.we = we; r.f = f;
    r.gnt = gnt; r.rv = rv; r.re = re; r.wr = wr; r.bsy = bsy; r.addr = addr;
    return r;
  endfunction

  row_t tbl[30];
  logic [9:0] sb[$];   // {owner, data}: owner 0=vec 1=dat 2=fet

  task automatic check_rvalid(input int idx);
    logic [9:0] e;
    logic [1:0] own;
    if (vec_rvalid || dat_rvalid || fet_rvalid) begin
      own = vec_rvalid ? 2'd0 : dat_rvalid ? 2'd1 : 2'd2;
      if (sb.size() == 0) begin
        check($sformatf("r%0d rvalid unexpected", idx), 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("r%0d rd_owner", idx), own, e[9:8]);
        check($sformatf("r%0d rdata", idx), rdata, e[7:0]);
      end
    end
  endtask

  initial begin
    // Conflicting VEC/FET, starvation guard, write-then-fetch, triple priority, WAIT hold-off.
    tbl[0]  = mk(0,0,0,1, 3'b001, 3'b000, 1,0,0, 12'h010);
    tbl[1]  = mk(0,0,0,0, 3'b000, 3'b000, 0,0,1, 12'h010);
    tbl[2]  = mk(0,0,0,0, 3'b000, 3'b001, 0,0,0, 12'h010);
    tbl[3]  = mk(1,0,0,1, 3'b100, 3'b000, 1,0,0, 12'h001);
    tbl[4]  = mk(0,0,0,1, 3'b000, 3'b000, 0,0,1, 12'h001);
    tbl[5]  = mk(0,0,0,1, 3'b001, 3'b100, 1,0,0, 12'h010);
    tbl[6]  = mk(0,0,0,0, 3'b000, 3'b000, 0,0,1, 12'h010);
    tbl[7]  = mk(0,0,0,0, 3'b000, 3'b001, 0,0,0, 12'h010);
    tbl[8]  = mk(0,1,1,1, 3'b010, 3'b000, 0,1,0, 12'h3FF);
    tbl[9]  = mk(0,1,1,1, 3'b010, 3'b000, 0,1,0, 12'h3FF);
    tbl[10] = mk(0,1,1,1, 3'b010, 3'b000, 0,1,0, 12'h3FF);
    tbl[11] = mk(0,1,1,1, 3'b001, 3'b000, 1,0,0, 12'h010);
    tbl[12] = mk(0,1,1,0, 3'b000, 3'b000, 0,0,1, 12'h010);
    tbl[13] = mk(0,1,1,0, 3'b010, 3'b001, 0,1,0, 12'h3FF);
    tbl[14] = mk(0,0,0,0, 3'b000, 3'b000, 0,0,0, 12'h010);
    tbl[15] = mk(0,1,1,1, 3'b010, 3'b000, 0,1,0, 12'h3FF);
    tbl[16] = mk(0,0,0,1, 3'b001, 3'b000, 1,0,0, 12'h010);
    tbl[17] = mk(0,0,0,0, 3'b000, 3'b000, 0,0,1, 12'h010);
    tbl[18] = mk(0,0,0,0, 3'b000, 3'b001, 0,0,0, 12'h010);
    tbl[19] = mk(1,1,0,1, 3'b100, 3'b000, 1,0,0, 12'h001);
    tbl[20] = mk(0,1,0,1, 3'b000, 3'b000, 0,0,1, 12'h001);
    tbl[21] = mk(0,1,0,1, 3'b010, 3'b100, 1,0,0, 12'h3FF);
    tbl[22] = mk(0,0,0,1, 3'b000, 3'b000, 0,0,1, 12'h3FF);
    tbl[23] = mk(0,0,0,1, 3'b001, 3'b010, 1,0,0, 12'h010);
    tbl[24] = mk(0,0,0,0, 3'b000, 3'b000, 0,0,1, 12'h010);
    tbl[25] = mk(0,0,0,0, 3'b000, 3'b001, 0,0,0, 12'h010);
    tbl[26] = mk(1,0,0,0, 3'b100, 3'b000, 1,0,0, 12'h001);
    tbl[27] = mk(0,1,0,0, 3'b000, 3'b000, 0,0,1, 12'h001);
    tbl[28] = mk(0,0,0,0, 3'b000, 3'b100, 0,0,0, 12'h001);
    tbl[29] = mk(0,0,0,0, 3'b000, 3'b000, 0,0,0, 12'h001);

    // Reset with a request present: everything must stay at reset values.
    fet_req = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("rst gnt", {vec_gnt, dat_gnt, fet_gnt}, 3'b000);
    check("rst rvalid", {vec_rvalid, dat_rvalid, fet_rvalid}, 3'b000);
    check("rst mem_re_we", {mem_re, mem_we}, 2'b00);
    check("rst busy", busy, 0);
    check("rst mem_addr", mem_addr, 12'h000);
    check("rst mem_wdata", mem_wdata, 8'h00);
    check("rst rdata", rdata, 8'h00);
    @(negedge clk);
    fet_req = 1'b0;
    reset   = 1'b0;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      vec_req = tbl[i].v;
      dat_req = tbl[i].d;
      dat_we  = tbl[i].we;
      fet_req = tbl[i].f;
      if (tbl[i].re)
        sb.push_back({(tbl[i].gnt[2] ? 2'd0 : tbl[i].gnt[1] ? 2'd1 : 2'd2), rom(tbl[i].addr)});
      #2;
      check($sformatf("r%0d gnt", i), {vec_gnt, dat_gnt, fet_gnt}, tbl[i].gnt);
      check($sformatf("r%0d rvalid", i), {vec_rvalid, dat_rvalid, fet_rvalid}, tbl[i].rv);
      check($sformatf("r%0d mem_re", i), mem_re, tbl[i].re);
      check($sformatf("r%0d mem_we", i), mem_we, tbl[i].wr);
      check($sformatf("r%0d busy", i), busy, tbl[i].bsy);
      check($sformatf("r%0d mem_addr", i), mem_addr, tbl[i].addr);
      check($sformatf("r%0d mem_wdata", i), mem_wdata, tbl[i].wr ? 8'h5C : 8'h00);
      check_rvalid(i);
    end
    check("sb drained", sb.size(), 0);

`ifdef MEM_ARB_PERF_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec_req = 1'b1; fet_req = 1'b1;
    @(negedge clk);
    vec_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fet_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("conflict_cnt", conflict_cnt, 16'd2);
`endif

    // LAT=3: full read, then a read interrupted by reset in its first WAIT cycle.
    @(negedge clk);
    l3_reset = 1'b0;
    @(negedge clk);
    l3_dat_req = 1'b1;
    #2;
    check("l3 dat_gnt", {l3_vg, l3_dg, l3_fg}, 3'b010);
    check("l3 mem_re", l3_mem_re, 1);
    check("l3 mem_addr", l3_mem_addr, 12'h123);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      l3_dat_req = 1'b0;
      #2;
      check($sformatf("l3 busy k%0d", k), l3_busy, (k <= 3) ? 1 : 0);
      check($sformatf("l3 dat_rvalid k%0d", k), l3_dr, (k == 4) ? 1 : 0);
    end
    check("l3 rdata", l3_rdata, 8'h96);

    @(negedge clk);
    l3_dat_req  = 1'b1;
    l3_dat_addr = 12'h0AB;
    #2;
    check("l3b dat_gnt", l3_dg, 1);
    @(negedge clk);
    l3_dat_req = 1'b0;
    l3_reset   = 1'b1;
    #2;
    check("l3b busy pre-reset", l3_busy, 1);
    @(negedge clk);
    l3_reset = 1'b0;
    #2;
    check("l3b busy", l3_busy, 0);
    check("l3b mem_addr", l3_mem_addr, 12'h000);
    check("l3b rdata", l3_rdata, 8'h00);
    check("l3b mem_re_we", {l3_mem_re, l3_mem_we}, 2'b00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #2;
      check($sformatf("l3b rvalid k%0d", k), {l3_vr, l3_dr, l3_fr}, 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
